// File: rtl/lsu_ctrl_pkg.sv
// Shared types and constants for the load/store controller.
package lsu_ctrl_pkg;

  // Access size encoding as presented on req_size_i; 2'b11 is illegal.
  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_e;

  // Controller FSM states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RMW   = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } lsu_state_e;

  localparam int LSU_DATA_W = 32;
  localparam int LSU_LANES  = LSU_DATA_W / 8;

  // Size 2'b11 has no meaning and is always rejected.
  function automatic logic size_illegal(input logic [1:0] size);
    return size == 2'b11;
  endfunction

endpackage

// File: rtl/defines.sv
// Build-time options for the load/store controller.
//
// LSU_MISALIGN_TRAP_EN
//   Undefined (default): misaligned half/word accesses are force-aligned and
//   proceed; only size 2'b11 raises rsp_err_o.
//   Defined: a misaligned half/word access returns an error response one cycle
//   after accept and never touches the RAM.
//
// Enable by uncommenting the line below or by passing +define+ on the command
// line to every compile of the RTL and bench.
//
// `define LSU_MISALIGN_TRAP_EN

// File: rtl/lsu_lane_align.sv
// Byte-lane steering between a RAM word and the pipeline.
// Loads: pick the addressed byte/half/word and sign- or zero-extend it.
// Stores: merge the right-aligned store data into the addressed lane(s) of the
// word just read, producing the write-back word for read-modify-write.
import lsu_ctrl_pkg::*;

module lsu_lane_align #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        off,
  input  mem_size_e         size,
  input  logic              uns,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] st_data
);

  logic [4:0]        shamt;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] lane_mask;

  // Shift the addressed lane down to bit 0 and build the lane mask.
  always_comb begin
    shamt     = {off, 3'b000};
    shifted   = rdata >> shamt;
    lane_mask = '1;
    case (size)
      MEM_B:   lane_mask = DATA_W'(8'hFF);
      MEM_H:   lane_mask = DATA_W'(16'hFFFF);
      default: lane_mask = '1;
    endcase
  end

  // Extend the selected lane for loads.
  always_comb begin
    ld_data = '0;
    case (size)
      MEM_B:   ld_data = uns ? {{(DATA_W-8){1'b0}}, shifted[7:0]}
                             : {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
      MEM_H:   ld_data = uns ? {{(DATA_W-16){1'b0}}, shifted[15:0]}
                             : {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      MEM_W:   ld_data = rdata;
      default: ld_data = '0;
    endcase
  end

  // Replace the addressed lane(s) with store data; a word store replaces all.
  always_comb begin
    st_data = (rdata & ~(lane_mask << shamt)) | ((wdata & lane_mask) << shamt);
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller in front of the data RAM (word-addressed, synchronous
// write, combinational read). One request in flight; sub-word stores are
// read-modify-write. Optional macro: LSU_MISALIGN_TRAP_EN (see defines.sv).
//
// Handshakes: a request transfers on the rising edge where req_valid_i and
// req_ready_o are both 1; a response transfers on the rising edge where
// rsp_valid_o and rsp_ready_i are both 1. While rsp_valid_o is 1 the response
// payload does not change, and requests presented outside IDLE are dropped.
//
// rst_n is active-high despite its name.
import lsu_ctrl_pkg::*;

module lsu_ctrl #(
  parameter int DATA_W = 32,
  parameter int RAM_AW = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [31:0]       req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic [RAM_AW-1:0] ram_raddr_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic [RAM_AW-1:0] ram_waddr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  output logic              ram_we_o,
  output lsu_state_e        dbg_state
);

  lsu_state_e        state;
  logic              we_q;
  logic              uns_q;
  mem_size_e         size_q;
  logic [1:0]        off_q;
  logic [RAM_AW-1:0] word_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] wbuf_q;
  logic [RAM_AW-1:0] waddr_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic [1:0]        acc_off;
  logic              acc_illegal;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] st_data;
  logic              lsu_unused_addr;

  // Address bits above the RAM window are deliberately ignored (wrap-around).
  assign lsu_unused_addr = ^req_addr_i[31:RAM_AW+2];

  // Classify the incoming request: lane offset after alignment and legality.
  always_comb begin
    acc_off     = req_addr_i[1:0];
    acc_illegal = size_illegal(req_size_i);
`ifdef LSU_MISALIGN_TRAP_EN
    if (req_size_i == MEM_H && req_addr_i[0])         acc_illegal = 1'b1;
    if (req_size_i == MEM_W && req_addr_i[1:0] != 2'b00) acc_illegal = 1'b1;
`else
    if (req_size_i == MEM_H) acc_off[0] = 1'b0;
    if (req_size_i == MEM_W) acc_off    = 2'b00;
`endif
  end

  lsu_lane_align #(.DATA_W(DATA_W)) u_align (
    .rdata   (ram_rdata_i),
    .off     (off_q),
    .size    (size_q),
    .uns     (uns_q),
    .wdata   (wdata_q),
    .ld_data (ld_data),
    .st_data (st_data)
  );

  // Transaction FSM and all request/response/write-port registers.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state   <= ST_IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= MEM_B;
      off_q   <= 2'b00;
      word_q  <= '0;
      wdata_q <= '0;
      wbuf_q  <= '0;
      waddr_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid_i) begin
            we_q    <= req_we_i;
            uns_q   <= req_unsigned_i;
            size_q  <= mem_size_e'(req_size_i);
            off_q   <= acc_off;
            word_q  <= req_addr_i[RAM_AW+1:2];
            wdata_q <= req_wdata_i;
            rdata_q <= '0;
            err_q   <= 1'b0;
            if (acc_illegal) begin
              err_q <= 1'b1;
              state <= ST_RESP;
            end else if (!req_we_i) begin
              state <= ST_LOAD;
            end else if (req_size_i == MEM_W) begin
              wbuf_q  <= req_wdata_i;
              waddr_q <= req_addr_i[RAM_AW+1:2];
              state   <= ST_WRITE;
            end else begin
              state <= ST_RMW;
            end
          end
        end
        ST_LOAD: begin
          rdata_q <= ld_data;
          state   <= ST_RESP;
        end
        ST_RMW: begin
          wbuf_q  <= st_data;
          waddr_q <= word_q;
          state   <= ST_WRITE;
        end
        ST_WRITE: begin
          state <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready_i) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o = (state == ST_IDLE) && !rst_n;
  assign rsp_valid_o = (state == ST_RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign ram_raddr_o = word_q;
  assign ram_waddr_o = waddr_q;
  assign ram_wdata_o = wbuf_q;
  assign ram_we_o    = (state == ST_WRITE);
  assign dbg_state   = state;

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store controller sitting directly upstream of the data RAM in the MEM stage.
- Accepts one byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW request at a time from the pipeline.
- Drives the RAM's word-addressed synchronous-write / combinational-read ports and returns sign- or zero-extended load data.
- Sub-word stores are performed as read-modify-write.

Parameters:
- DATA_W, 32: RAM word width, bits; equals the RAMBus width.
- RAM_AW, 9: RAM word-address width; equals the RAMAddrBus width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-high (asserted = 1), despite the suffix.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid && ready.
- req_we_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  00 byte, 01 half, 10 word; 11 is illegal.
- req_unsigned_i  in  1  zero-extend load data (LBU/LHU).
- req_addr_i  in  32  byte address.
- req_wdata_i  in  DATA_W  store data, right-aligned.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed.
- rsp_rdata_o  out  DATA_W  extended load data; 0 for stores.
- rsp_err_o  out  1  misaligned address or illegal size.
- ram_raddr_o  out  RAM_AW  RAM read word address.
- ram_rdata_i  in  DATA_W  RAM read data (combinational).
- ram_waddr_o  out  RAM_AW  RAM write word address.
- ram_wdata_o  out  DATA_W  RAM write data.
- ram_we_o  out  1  RAM write enable.

Behaviour:
- Word address is addr[RAM_AW+1:2]. Bits above RAM_AW+1 are ignored, so addresses wrap. Byte lanes are little-endian: lane k = bits 8k+7:8k.
- States: IDLE, LOAD, RMW, WRITE, RESP.
- IDLE:
  - req_ready_o = 1.
  - On accept, register the request as a new transaction.
  - If the request is illegal (misaligned or size 11), set err and go to RESP.
  - Load goes to LOAD; word store goes to WRITE with wbuf = wdata; sub-word store goes to RMW.
- LOAD:
  - ram_raddr_o = word address.
  - Select the lane(s) by addr[1:0], then extend (sign, or zero if unsigned) and register into rsp_rdata.
  - Go to RESP.
- RMW:
  - ram_raddr_o = word address.
  - wbuf = ram_rdata_i with the addressed byte or half replaced by wdata[7:0] or wdata[15:0].
  - Go to WRITE.
- WRITE:
  - ram_we_o = 1 for exactly one cycle; ram_waddr_o = word address; ram_wdata_o = wbuf.
  - Go to RESP.
- RESP:
  - rsp_valid_o = 1; hold rsp_rdata_o and rsp_err_o stable until rsp_ready_i.
  - On rsp_ready_i, go to IDLE. The next request is accepted no earlier than the following cycle.
- Latency from the accept edge T to the first rsp_valid_o cycle:
  - load: T+2.
  - word store: T+2.
  - sub-word store: T+3.
  - error: T+1.
- req_ready_o = 0 outside IDLE. Requests there are ignored and not queued.
- ram_we_o is decoded from state alone, never from request inputs.
- When not in WRITE, ram_waddr_o and ram_wdata_o hold their last values. ram_raddr_o is undefined-but-stable outside LOAD/RMW (drive the registered word address).
- Reset values: state IDLE, req_ready_o 0 while reset is asserted, rsp_valid_o 0, rsp_rdata_o 0, rsp_err_o 0, ram_we_o 0, all addresses and wbuf 0.
- Reset asserted mid-transaction returns to IDLE immediately. An in-flight RMW/WRITE is aborted with no RAM write, and no response is issued.
- A store response carries rsp_rdata_o = 0.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: half access with addr[0] = 1, or word access with addr[1:0] != 0, produces an error response at T+1 with no RAM access.
- Undefined: misaligned addresses are force-aligned (half clears addr[0], word clears addr[1:0]) and the access proceeds normally. rsp_err_o is asserted only for size 11.

Decomposition:
- type_pkg additions:
  - mem_size_e: MEM_B, MEM_H, MEM_W.
  - lsu_state_e: the five states.
  - Byte-lane constant LSU_LANES = DATA_W/8.
- Macro LSU_MISALIGN_TRAP_EN lives in defines.sv.
- One combinational sub-module, lsu_lane_align, provides both lane extract/extend (loads) and lane merge (stores). The FSM and registers stay in lsu_ctrl.

Test Plan:
- Word store, then load: SW 0xDEADBEEF to 0x10, then LW 0x10. Required: exactly one ram_we_o pulse with waddr 4; rsp_rdata_o = 0xDEADBEEF at T+2.
- Sub-word RMW: word 4 = 0x11223344, then SB 0xAA to 0x12. Required: RMW read then write of 0x11AA3344; rsp_valid_o at T+3; one we pulse.
- Sign/zero extend: word 4 = 0x0000F080. LB 0x10 -> 0xFFFFFF80; LBU 0x10 -> 0x00000080; LH 0x10 -> 0xFFFFF080; LHU 0x12 -> 0x00000000.
- Backpressure: hold rsp_ready_i = 0 for 5 cycles after a load. Required: response data stable; req_ready_o = 0 throughout; a concurrent req_valid_i is ignored and ram_we_o stays 0.
- Misalign / illegal: LW 0x11 with macro defined -> rsp_err_o = 1 at T+1, no RAM access. Without the macro -> reads word 4. Size 11 -> error in both builds.
- Reset mid-RMW: assert rst_n during RMW of SH to 0x20. Required: immediate IDLE, no ram_we_o, no rsp_valid_o; word 8 unchanged.
